run_sequencer: RTL and testbench
================================

# run_sequencer

Frame-level controller for the running-man display datapath. Owns game state (obstacle column position, obstacle shapes, player lane and posture) and sequences the datapath's draw operations: floors once, then per frame erase → obstacle → man. It then checks for a collision and, on a hit, triggers the game-over screen. It sits between the key debouncers and the datapath, and drives every datapath control/load input.

## Interface
Parameters:
- FRAME_CYCLES, 833333, clock cycles per game frame (60 Hz at 50 MHz); minimum 2
- SCROLL_STEP, 1, pixels the obstacle column moves left per frame
- TREE_START, 156, obstacle x after reset and after each wrap
- MAN_X, 25, fixed left x of the man sprite (sprite spans MAN_X..MAN_X+6)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- key_up  in  1  level, synchronous; rising edge moves the man one lane up
- key_down  in  1  level, synchronous; rising edge moves the man one lane down
- key_crouch  in  1  level; 1 = crouch posture
- draw_floors_finish, erase_finish, draw_tree_finish, draw_man_finish, draw_gameover_finish  in  1 each  sticky datapath completion flags
- drawing_floors, erase, draw_tree, draw_man, gameover  out  1 each  datapath operation enables
- ld_x, ld_y, ld_man_style, ld_shape  out  1 each  one-cycle load strobes
- x_out  out  8  obstacle x (to datapath x_in)
- y_out  out  7  man top y (to datapath y_in)
- man_style  out  1  1 = normal, 0 = crouch
- top, mid, bottom  out  2 each  obstacle shape per lane: 00/01 top gap, 10 bottom gap, 11 wall
- update  out  1  one-cycle pulse at each frame tick

## Operation
- States:
  - FLOORS: drawing_floors=1 until draw_floors_finish, then go to WAIT.
  - WAIT: frame counter runs; at count FRAME_CYCLES-1, pulse update, advance game state, go to LOAD.
  - LOAD: one cycle; ld_x, ld_y, ld_man_style and ld_shape all =1; go to ERASE.
  - ERASE: erase=1 until erase_finish, then go to TREE.
  - TREE: draw_tree=1 until draw_tree_finish, then go to MAN.
  - MAN: draw_man=1 until draw_man_finish, then go to CHECK.
  - CHECK: one cycle; on a hit go to OVER, else go to WAIT.
  - OVER: gameover=1 until draw_gameover_finish, then go to DEAD.
  - DEAD: terminal; all enables 0; leaves only on reset_n.
- Completion flags are level-tested; each one is consumed only in its own state.
- Lane: 2-bit register, values 0..2. lane→y_out mapping: 0→28, 1→68, 2→108.
  - key_up edge: lane−1, saturating at 0. key_down edge: lane+1, saturating at 2.
  - Simultaneous up and down edges: lane unchanged.
  - Edges are detected every cycle in every state; they take effect at the next LOAD.
- man_style = ~key_crouch, sampled at the frame tick.
- Obstacle advance at frame tick:
  - If tree_x < SCROLL_STEP+2: tree_x←TREE_START and new shapes are drawn from the LFSR.
  - Else: tree_x←tree_x−SCROLL_STEP.
  - tree_x is 8-bit unsigned and never underflows.
- LFSR: 6-bit, taps x^6+x^5+1, seeded to 6'b000001 at reset, stepped every cycle. A new shape set takes lfsr[5:4], [3:2] and [1:0] as top, mid and bottom.
  - If all three shapes would be 11, bottom is forced to 10.
- Hit (CHECK state):
  - Overlap condition: tree_x+1 ≥ MAN_X and tree_x ≤ MAN_X+6. Compute in 9 bits.
  - The lane's shape is 11 → hit.
  - The lane's shape is 10 and man_style=1 → hit.
  - The lane's shape is 00/01 and man_style=0 → hit.
  - No overlap → no hit.

## Timing
- Reset values:
  - State FLOORS; drawing_floors=1 from reset; every other output 0.
  - x_out=156, y_out=108, man_style=1.
  - top=00, mid=10, bottom=11. These match the datapath's own reset values.
  - lane=2, frame counter=0.
- A frame tick occurs exactly FRAME_CYCLES cycles after entering WAIT, not counted from the previous tick. Draw time stretches the frame.
- Tick→LOAD: 1 cycle. LOAD→ERASE: 1 cycle.
- Enables assert the cycle the state is entered and deassert the cycle after the finish flag is seen.
- Exactly one datapath enable is high in any cycle.
- Every output is registered.
- Reset mid-operation: all state returns to reset values asynchronously. The sequence restarts at FLOORS.

## Test plan
- Reset, FRAME_CYCLES=4, datapath model finishes every operation in 3 cycles → drawing_floors high, then WAIT. After 4 cycles: update pulse, then one LOAD cycle with x_out=155, y_out=108. Then erase, tree and man in that order, with no overlap between enables.
- Run 153 frames with no keys → x_out steps 155…2. The next frame gives x_out=156 with new LFSR shapes; no shape set is ever all 11.
- key_up pulse twice, then a third time → y_out 68, then 28, then stays 28. Simultaneous up+down → y_out unchanged.
- Force bottom=10, lane 2, tree_x reaches 31, key_crouch=1 → no hit, game continues. Same setup with key_crouch=0 → gameover asserted until draw_gameover_finish, then DEAD with all outputs idle.
- Lane shape 11 at tree_x=24 → hit. At tree_x=23 → no hit (boundary).
- Assert reset_n low during TREE → draw_tree drops immediately. After release, state is FLOORS with reset values.

Source files
------------

// File: rtl/run_sequencer.sv
// Frame-level controller for the running-man display: owns obstacle/player state and
// sequences the datapath draw operations, collision check and game-over screen.
module run_sequencer #(
    parameter int unsigned FRAME_CYCLES = 833333,
    parameter int unsigned SCROLL_STEP  = 1,
    parameter int unsigned TREE_START   = 156,
    parameter int unsigned MAN_X        = 25
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_crouch,
    input  logic       draw_floors_finish,
    input  logic       erase_finish,
    input  logic       draw_tree_finish,
    input  logic       draw_man_finish,
    input  logic       draw_gameover_finish,
    output logic       drawing_floors,
    output logic       erase,
    output logic       draw_tree,
    output logic       draw_man,
    output logic       gameover,
    output logic       ld_x,
    output logic       ld_y,
    output logic       ld_man_style,
    output logic       ld_shape,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic       man_style,
    output logic [1:0] top,
    output logic [1:0] mid,
    output logic [1:0] bottom,
    output logic       update
);

    localparam int unsigned CntW = $clog2(FRAME_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(FRAME_CYCLES - 1);

    typedef enum logic [3:0] {
        StFloors, StWait, StLoad, StErase, StTree, StMan, StCheck, StOver, StDead
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [5:0]      lfsr_q, lfsr_d;
    logic            key_up_q, key_down_q;
    logic [1:0]      lane_q, lane_d;
    logic [1:0]      draw_lane_q, draw_lane_d;
    logic [7:0]      tree_x_q, tree_x_d;
    logic [1:0]      top_q, top_d, mid_q, mid_d, bot_q, bot_d;
    logic            style_q, style_d;
    logic [6:0]      y_q, y_d;
    logic            floors_q, floors_d, erase_q, erase_d, tree_q, tree_d;
    logic            man_q, man_d, over_q, over_d, ld_q, ld_d, update_q;
    logic            tick, hit, overlap, up_edge, dn_edge;
    logic [1:0]      lane_shape, new_bot;
    logic [8:0]      x9;

    // Collision uses the lane and posture that were actually drawn this frame.
    always_comb begin
        x9      = {1'b0, tree_x_q};
        overlap = (x9 + 9'd1 >= 9'(MAN_X)) && (x9 <= 9'(MAN_X + 6));
        unique case (draw_lane_q)
            2'd0:    lane_shape = top_q;
            2'd1:    lane_shape = mid_q;
            default: lane_shape = bot_q;
        endcase
        hit = overlap && ((lane_shape == 2'b11) ||
                          (lane_shape == 2'b10 && style_q) ||
                          (!lane_shape[1] && !style_q));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        tick    = 1'b0;
        unique case (state_q)
            StFloors: if (draw_floors_finish) state_d = StWait;
            StWait: begin
                if (cnt_q == CntLast) begin
                    tick    = 1'b1;
                    state_d = StLoad;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StLoad:  state_d = StErase;
            StErase: if (erase_finish) state_d = StTree;
            StTree:  if (draw_tree_finish) state_d = StMan;
            StMan:   if (draw_man_finish) state_d = StCheck;
            StCheck: state_d = hit ? StOver : StWait;
            StOver:  if (draw_gameover_finish) state_d = StDead;
            StDead:  state_d = StDead;
            default: state_d = StFloors;
        endcase
        floors_d = (state_d == StFloors);
        erase_d  = (state_d == StErase);
        tree_d   = (state_d == StTree);
        man_d    = (state_d == StMan);
        over_d   = (state_d == StOver);
        ld_d     = (state_d == StLoad);
    end

    always_comb begin
        lfsr_d  = {lfsr_q[4:0], lfsr_q[5] ^ lfsr_q[4]};
        up_edge = key_up & ~key_up_q;
        dn_edge = key_down & ~key_down_q;
        lane_d  = lane_q;
        if (up_edge && !dn_edge && lane_q != 2'd0) begin
            lane_d = lane_q - 2'd1;
        end else if (dn_edge && !up_edge && lane_q < 2'd2) begin
            lane_d = lane_q + 2'd1;
        end
        new_bot = (lfsr_q == 6'b111111) ? 2'b10 : lfsr_q[1:0];

        tree_x_d    = tree_x_q;
        top_d       = top_q;
        mid_d       = mid_q;
        bot_d       = bot_q;
        style_d     = style_q;
        y_d         = y_q;
        draw_lane_d = draw_lane_q;
        if (tick) begin
            style_d     = ~key_crouch;
            draw_lane_d = lane_d;
            unique case (lane_d)
                2'd0:    y_d = 7'd28;
                2'd1:    y_d = 7'd68;
                default: y_d = 7'd108;
            endcase
            if (x9 < 9'(SCROLL_STEP + 2)) begin
                tree_x_d = 8'(TREE_START);
                top_d    = lfsr_q[5:4];
                mid_d    = lfsr_q[3:2];
                bot_d    = new_bot;
            end else begin
                tree_x_d = tree_x_q - 8'(SCROLL_STEP);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StFloors;
            cnt_q       <= '0;
            lfsr_q      <= 6'b000001;
            key_up_q    <= 1'b0;
            key_down_q  <= 1'b0;
            lane_q      <= 2'd2;
            draw_lane_q <= 2'd2;
            tree_x_q    <= 8'(TREE_START);
            top_q       <= 2'b00;
            mid_q       <= 2'b10;
            bot_q       <= 2'b11;
            style_q     <= 1'b1;
            y_q         <= 7'd108;
            floors_q    <= 1'b1;
            erase_q     <= 1'b0;
            tree_q      <= 1'b0;
            man_q       <= 1'b0;
            over_q      <= 1'b0;
            ld_q        <= 1'b0;
            update_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lfsr_q      <= lfsr_d;
            key_up_q    <= key_up;
            key_down_q  <= key_down;
            lane_q      <= lane_d;
            draw_lane_q <= draw_lane_d;
            tree_x_q    <= tree_x_d;
            top_q       <= top_d;
            mid_q       <= mid_d;
            bot_q       <= bot_d;
            style_q     <= style_d;
            y_q         <= y_d;
            floors_q    <= floors_d;
            erase_q     <= erase_d;
            tree_q      <= tree_d;
            man_q       <= man_d;
            over_q      <= over_d;
            ld_q        <= ld_d;
            update_q    <= tick;
        end
    end

    assign drawing_floors = floors_q;
    assign erase          = erase_q;
    assign draw_tree      = tree_q;
    assign draw_man       = man_q;
    assign gameover       = over_q;
    assign ld_x           = ld_q;
    assign ld_y           = ld_q;
    assign ld_man_style   = ld_q;
    assign ld_shape       = ld_q;
    assign x_out          = tree_x_q;
    assign y_out          = y_q;
    assign man_style      = style_q;
    assign top            = top_q;
    assign mid            = mid_q;
    assign bottom         = bot_q;
    assign update         = update_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer with a 3-cycle datapath model and FRAME_CYCLES=4.
module tb_run_sequencer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic key_up = 1'b0, key_down = 1'b0, key_crouch = 1'b0;
    logic floors_fin, erase_fin, tree_fin, man_fin, over_fin;
    logic drawing_floors, erase, draw_tree, draw_man, gameover;
    logic ld_x, ld_y, ld_man_style, ld_shape, man_style, update;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [1:0] top, mid, bottom;

    int n_cmp = 0;
    int n_bad = 0;
    int fr = 0;
    logic multi_en = 1'b0;

    run_sequencer #(
        .FRAME_CYCLES(4), .SCROLL_STEP(1), .TREE_START(156), .MAN_X(25)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .key_up(key_up), .key_down(key_down), .key_crouch(key_crouch),
        .draw_floors_finish(floors_fin), .erase_finish(erase_fin),
        .draw_tree_finish(tree_fin), .draw_man_finish(man_fin),
        .draw_gameover_finish(over_fin),
        .drawing_floors(drawing_floors), .erase(erase), .draw_tree(draw_tree),
        .draw_man(draw_man), .gameover(gameover),
        .ld_x(ld_x), .ld_y(ld_y), .ld_man_style(ld_man_style), .ld_shape(ld_shape),
        .x_out(x_out), .y_out(y_out), .man_style(man_style),
        .top(top), .mid(mid), .bottom(bottom), .update(update)
    );

    always #5 clk = ~clk;

    // Datapath model: finish flag rises on the 3rd cycle of an enable, clears when it drops.
    logic [1:0] c_fl, c_er, c_tr, c_mn, c_go;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_fl <= 0; c_er <= 0; c_tr <= 0; c_mn <= 0; c_go <= 0;
            floors_fin <= 0; erase_fin <= 0; tree_fin <= 0; man_fin <= 0; over_fin <= 0;
        end else begin
            if (drawing_floors) begin
                if (c_fl != 3) c_fl <= c_fl + 1;
                floors_fin <= (c_fl >= 2);
            end else begin c_fl <= 0; floors_fin <= 0; end
            if (erase) begin
                if (c_er != 3) c_er <= c_er + 1;
                erase_fin <= (c_er >= 2);
            end else begin c_er <= 0; erase_fin <= 0; end
            if (draw_tree) begin
                if (c_tr != 3) c_tr <= c_tr + 1;
                tree_fin <= (c_tr >= 2);
            end else begin c_tr <= 0; tree_fin <= 0; end
            if (draw_man) begin
                if (c_mn != 3) c_mn <= c_mn + 1;
                man_fin <= (c_mn >= 2);
            end else begin c_mn <= 0; man_fin <= 0; end
            if (gameover) begin
                if (c_go != 3) c_go <= c_go + 1;
                over_fin <= (c_go >= 2);
            end else begin c_go <= 0; over_fin <= 0; end
        end
    end

    // Reference x^6+x^5+1 LFSR; lfsr_prev holds the value the DUT sampled at the last edge.
    logic [5:0] lfsr_m, lfsr_prev;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_m <= 6'b000001; lfsr_prev <= 6'b000001;
        end else begin
            lfsr_m <= {lfsr_m[4:0], lfsr_m[5] ^ lfsr_m[4]}; lfsr_prev <= lfsr_m;
        end
    end

    always @(negedge clk) begin
        if ($countones({drawing_floors, erase, draw_tree, draw_man, gameover}) > 1)
            multi_en <= 1'b1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_load(output bit got, output bit over);
        got = 0; over = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (gameover) begin over = 1; break; end
            if (ld_x) begin got = 1; break; end
        end
    endtask

    task automatic run_to(input int target, output bit ok);
        bit g, o;
        ok = 1;
        while (ok && fr < target) begin
            wait_load(g, o);
            if (!g || o) ok = 0;
            else fr++;
        end
    endtask

    task automatic pulse(input logic up, input logic dn);
        @(negedge clk); key_up = up; key_down = dn;
        @(negedge clk); key_up = 1'b0; key_down = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 0; key_up = 0; key_down = 0; key_crouch = 0;
        repeat (3) @(negedge clk);
        reset_n = 1;
        fr = 0;
    endtask

    task automatic test_reset();
        int ld_first, ld_n, up_cyc, fl_last, er_f, er_l, tr_f, tr_l, mn_f, mn_l;
        logic [7:0] ld_xv; logic [6:0] ld_yv; logic ld_all;
        reset_n = 0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({drawing_floors, erase, draw_tree, draw_man, gameover} !== 5'b10000) begin
            n_bad++; $display("FAIL reset_enables: got %b want 10000",
                              {drawing_floors, erase, draw_tree, draw_man, gameover});
        end
        n_cmp++;
        if ({ld_x, ld_y, ld_man_style, ld_shape, update} !== 5'b0) begin
            n_bad++; $display("FAIL reset_strobes: got %b want 00000",
                              {ld_x, ld_y, ld_man_style, ld_shape, update});
        end
        n_cmp++;
        if ({x_out, y_out, man_style} !== {8'd156, 7'd108, 1'b1}) begin
            n_bad++; $display("FAIL reset_xy: got x=%0d y=%0d style=%b want 156 108 1",
                              x_out, y_out, man_style);
        end
        n_cmp++;
        if ({top, mid, bottom} !== 6'b00_10_11) begin
            n_bad++; $display("FAIL reset_shapes: got %b want 001011", {top, mid, bottom});
        end
        reset_n = 1;
        ld_first = 0; ld_n = 0; up_cyc = 0; fl_last = 0; ld_all = 0; ld_xv = 0; ld_yv = 0;
        er_f = 0; er_l = 0; tr_f = 0; tr_l = 0; mn_f = 0; mn_l = 0;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            if (drawing_floors) fl_last = c;
            if (update) up_cyc = c;
            if (ld_x) begin
                ld_n++;
                if (ld_first == 0) begin
                    ld_first = c; ld_xv = x_out; ld_yv = y_out;
                    ld_all = ld_y & ld_man_style & ld_shape;
                end
            end
            if (erase) begin if (er_f == 0) er_f = c; er_l = c; end
            if (draw_tree) begin if (tr_f == 0) tr_f = c; tr_l = c; end
            if (draw_man) begin if (mn_f == 0) mn_f = c; mn_l = c; end
        end
        fr = 1;
        n_cmp++;
        if (fl_last != 3) begin
            n_bad++; $display("FAIL floors_last: got %0d want 3", fl_last);
        end
        n_cmp++;
        if (ld_first != 8 || ld_n != 1 || up_cyc != 8 || ld_all !== 1'b1) begin
            n_bad++; $display("FAIL first_load: got cyc=%0d n=%0d upd=%0d all=%b want 8 1 8 1",
                              ld_first, ld_n, up_cyc, ld_all);
        end
        n_cmp++;
        if (ld_xv !== 8'd155 || ld_yv !== 7'd108) begin
            n_bad++; $display("FAIL first_load_xy: got x=%0d y=%0d want 155 108", ld_xv, ld_yv);
        end
        n_cmp++;
        if ({er_f, er_l, tr_f, tr_l, mn_f, mn_l} !== {32'd9, 32'd12, 32'd13, 32'd16, 32'd17, 32'd20})
        begin
            n_bad++; $display("FAIL draw_order: got er %0d-%0d tr %0d-%0d mn %0d-%0d want 9-12 13-16 17-20",
                              er_f, er_l, tr_f, tr_l, mn_f, mn_l);
        end
    endtask

    task automatic test_lanes();
        bit g, o;
        logic [6:0] exp_y [4] = '{7'd68, 7'd68, 7'd28, 7'd28};
        logic [1:0] ups [4]   = '{2'b10, 2'b11, 2'b10, 2'b10};
        for (int i = 0; i < 4; i++) begin
            pulse(ups[i][1], ups[i][0] & ups[i][1]);
            wait_load(g, o);
            fr++;
            n_cmp++;
            if (!g || y_out !== exp_y[i] || x_out !== 8'(156 - fr)) begin
                n_bad++; $display("FAIL lane_step%0d: got load=%b y=%0d x=%0d want 1 %0d %0d",
                                  i, g, y_out, x_out, exp_y[i], 156 - fr);
            end
        end
        key_crouch = 1;
        wait_load(g, o); fr++;
        n_cmp++;
        if (!g || man_style !== 1'b0) begin
            n_bad++; $display("FAIL crouch_style: got load=%b style=%b want 1 0", g, man_style);
        end
        key_crouch = 0;
        wait_load(g, o); fr++;
        n_cmp++;
        if (!g || man_style !== 1'b1) begin
            n_bad++; $display("FAIL stand_style: got load=%b style=%b want 1 1", g, man_style);
        end
    endtask

    task automatic test_wrap();
        bit g, o;
        logic [1:0] et, em, eb;
        while (fr < 154) begin
            wait_load(g, o);
            fr++;
            n_cmp++;
            if (!g || x_out !== 8'(156 - fr)) begin
                n_bad++; $display("FAIL scroll_x fr%0d: got load=%b x=%0d want 1 %0d",
                                  fr, g, x_out, 156 - fr);
                if (!g) return;
            end
        end
        wait_load(g, o);
        fr++;
        et = lfsr_prev[5:4]; em = lfsr_prev[3:2]; eb = lfsr_prev[1:0];
        if (et == 2'b11 && em == 2'b11 && eb == 2'b11) eb = 2'b10;
        n_cmp++;
        if (!g || x_out !== 8'd156) begin
            n_bad++; $display("FAIL wrap_x: got load=%b x=%0d want 1 156", g, x_out);
        end
        n_cmp++;
        if ({top, mid, bottom} !== {et, em, eb}) begin
            n_bad++; $display("FAIL wrap_shapes: got %b want %b", {top, mid, bottom}, {et, em, eb});
        end
        n_cmp++;
        if ({top, mid, bottom} === 6'b111111) begin
            n_bad++; $display("FAIL wrap_not_wall: got %b want not 111111", {top, mid, bottom});
        end
    endtask

    task automatic test_crouch_safe();
        bit g, o, ok;
        do_reset();
        run_to(1, ok);
        pulse(1, 0);
        key_crouch = 1;
        run_to(133, ok);
        n_cmp++;
        if (!ok || fr != 133 || x_out !== 8'd23 || y_out !== 7'd68 || man_style !== 1'b0) begin
            n_bad++; $display("FAIL crouch_safe: got fr=%0d x=%0d y=%0d style=%b want 133 23 68 0",
                              fr, x_out, y_out, man_style);
        end
        key_crouch = 0;
    endtask

    task automatic test_crouch_hit();
        bit g, o, ok;
        int go_n;
        logic idle_or;
        do_reset();
        run_to(1, ok);
        pulse(1, 0);
        run_to(125, ok);
        n_cmp++;
        if (!ok || x_out !== 8'd31 || y_out !== 7'd68) begin
            n_bad++; $display("FAIL hit_approach: got ok=%b x=%0d y=%0d want 1 31 68",
                              ok, x_out, y_out);
        end
        wait_load(g, o);
        n_cmp++;
        if (!o || g) begin
            n_bad++; $display("FAIL hit_gameover: got over=%b load=%b want 1 0", o, g);
        end
        go_n = o ? 1 : 0;
        for (int i = 0; i < 20 && o; i++) begin
            @(negedge clk);
            if (!gameover) break;
            go_n++;
        end
        n_cmp++;
        if (go_n != 4) begin
            n_bad++; $display("FAIL gameover_len: got %0d cycles want 4", go_n);
        end
        idle_or = 0;
        repeat (10) begin
            @(negedge clk);
            idle_or |= |{drawing_floors, erase, draw_tree, draw_man, gameover,
                         ld_x, ld_y, ld_man_style, ld_shape, update};
        end
        n_cmp++;
        if (idle_or !== 1'b0) begin
            n_bad++; $display("FAIL dead_idle: got activity=%b want 0", idle_or);
        end
    endtask

    task automatic test_boundary(input int pre_fr, input bit exp_hit);
        bit g, o, ok;
        do_reset();
        run_to(1, ok);
        pulse(1, 0);
        pulse(1, 0);
        run_to(pre_fr, ok);
        pulse(0, 1);
        pulse(0, 1);
        wait_load(g, o);
        fr++;
        n_cmp++;
        if (!ok || !g || x_out !== 8'(156 - fr) || y_out !== 7'd108) begin
            n_bad++; $display("FAIL edge_load x%0d: got ok=%b load=%b x=%0d y=%0d want 1 1 %0d 108",
                              156 - fr, ok, g, x_out, y_out, 156 - fr);
        end
        wait_load(g, o);
        n_cmp++;
        if (o !== exp_hit || g !== !exp_hit) begin
            n_bad++; $display("FAIL edge_hit x%0d: got over=%b load=%b want over=%b",
                              156 - fr, o, g, exp_hit);
        end
    endtask

    task automatic test_reset_mid();
        bit g, o, ok;
        int cyc;
        do_reset();
        run_to(1, ok);
        pulse(1, 0);
        for (int i = 0; i < 50 && !draw_tree; i++) @(negedge clk);
        #2 reset_n = 0;
        #1;
        n_cmp++;
        if (draw_tree !== 1'b0 || drawing_floors !== 1'b1 || x_out !== 8'd156 ||
            y_out !== 7'd108 || man_style !== 1'b1 || {top, mid, bottom} !== 6'b001011) begin
            n_bad++; $display("FAIL midreset: got tree=%b fl=%b x=%0d y=%0d st=%b sh=%b want 0 1 156 108 1 001011",
                              draw_tree, drawing_floors, x_out, y_out, man_style, {top, mid, bottom});
        end
        @(negedge clk);
        reset_n = 1;
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (ld_x) begin cyc = i; break; end
        end
        n_cmp++;
        if (cyc != 8 || x_out !== 8'd155 || y_out !== 7'd108) begin
            n_bad++; $display("FAIL midreset_restart: got cyc=%0d x=%0d y=%0d want 8 155 108",
                              cyc, x_out, y_out);
        end
    endtask

    task automatic test_exclusive();
        n_cmp++;
        if (multi_en !== 1'b0) begin
            n_bad++; $display("FAIL enable_overlap: got %b want 0", multi_en);
        end
    endtask

    initial begin
        test_reset();
        test_lanes();
        test_wrap();
        test_crouch_safe();
        test_crouch_hit();
        test_boundary(131, 1'b1);
        test_boundary(132, 1'b0);
        test_reset_mid();
        test_exclusive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
